// File: rtl/uart_command_decoder.sv
// Host command decoder: unloads UART RX bytes, frames opcode + args, and applies
// capture configuration updates only while the capture controller is idle.
module uart_command_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter logic [2:0]  MASK_RESET     = 3'b111,
    parameter logic [15:0] DIV_RESET      = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        UART_rxempty,
    input  logic [7:0]  UART_rxdata,
    input  logic        capture_busy,
    output logic        UART_uld_rx_data,
    output logic [2:0]  triggerBlock_Mask,
    output logic [15:0] Sample_Div,
    output logic        Rearm,
    output logic        cmd_valid,
    output logic        cmd_error,
    output logic [2:0]  state_debug
);

    localparam int unsigned   CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OpMask  = 8'h4D;
    localparam logic [7:0] OpDiv   = 8'h44;
    localparam logic [7:0] OpRearm = 8'h52;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StUnload  = 3'd1,
        StLatch   = 3'd2,
        StDecode  = 3'd3,
        StWaitArg = 3'd4,
        StApply   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      opcode_q, opcode_d;
    logic [7:0]      arg0_q, arg0_d;
    logic [7:0]      arg1_q, arg1_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      mask_q, mask_d;
    logic [15:0]     div_q, div_d;
    logic            rearm_q, rearm_d;
    logic            valid_q, valid_d;
    logic            error_q, error_d;

    logic            known;
    logic [1:0]      nargs;

    always_comb begin
        known = 1'b1;
        nargs = 2'd0;
        case (opcode_q)
            OpMask:  nargs = 2'd1;
            OpDiv:   nargs = 2'd2;
            OpRearm: nargs = 2'd0;
            default: known = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opcode_d = opcode_q;
        arg0_d   = arg0_q;
        arg1_d   = arg1_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        div_d    = div_q;
        rearm_d  = 1'b0;
        valid_d  = 1'b0;
        error_d  = error_q;

        case (state_q)
            StIdle: begin
                idx_d = 2'd0;
                if (!UART_rxempty) state_d = StUnload;
            end
            StUnload: state_d = StLatch;
            StLatch: begin
                if (idx_q == 2'd0)      opcode_d = UART_rxdata;
                else if (idx_q == 2'd1) arg0_d   = UART_rxdata;
                else                    arg1_d   = UART_rxdata;
                idx_d   = idx_q + 2'd1;
                state_d = StDecode;
            end
            StDecode: begin
                if (!known) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else if (idx_q == nargs + 2'd1) begin
                    state_d = StApply;
                end else begin
                    cnt_d   = '0;
                    state_d = StWaitArg;
                end
            end
            StWaitArg: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                // A pending byte takes priority over timeout expiry in the same cycle.
                if (!UART_rxempty) begin
                    state_d = StUnload;
                end else if (cnt_q == CntLast) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StApply: begin
                if (!capture_busy) begin
                    case (opcode_q)
                        OpMask:  mask_d  = arg0_q[2:0];
                        OpDiv:   div_d   = {arg1_q, arg0_q};
                        OpRearm: rearm_d = 1'b1;
                        default: ;
                    endcase
                    valid_d = 1'b1;
                    error_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= 2'd0;
            opcode_q <= 8'd0;
            arg0_q   <= 8'd0;
            arg1_q   <= 8'd0;
            cnt_q    <= '0;
            mask_q   <= MASK_RESET;
            div_q    <= DIV_RESET;
            rearm_q  <= 1'b0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opcode_q <= opcode_d;
            arg0_q   <= arg0_d;
            arg1_q   <= arg1_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            div_q    <= div_d;
            rearm_q  <= rearm_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign UART_uld_rx_data  = (state_q == StUnload);
    assign triggerBlock_Mask = mask_q;
    assign Sample_Div        = div_q;
    assign Rearm             = rearm_q;
    assign cmd_valid         = valid_q;
    assign cmd_error         = error_q;
    assign state_debug       = state_q;

endmodule

// File: tb/tb_uart_command_decoder.sv
// Bench for uart_command_decoder: queue-backed UART model, command-level reference
// model feeding a scoreboard checked on every cmd_valid/Rearm pulse.
module tb_uart_command_decoder;

    localparam int unsigned Timeout = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        UART_rxempty;
    logic [7:0]  UART_rxdata;
    logic        capture_busy;
    logic        UART_uld_rx_data;
    logic [2:0]  triggerBlock_Mask;
    logic [15:0] Sample_Div;
    logic        Rearm;
    logic        cmd_valid;
    logic        cmd_error;
    logic [2:0]  state_debug;

    always #5 clk = ~clk;

    uart_command_decoder #(
        .TIMEOUT_CYCLES(Timeout),
        .MASK_RESET    (3'b111),
        .DIV_RESET     (16'd0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .UART_rxempty     (UART_rxempty),
        .UART_rxdata      (UART_rxdata),
        .capture_busy     (capture_busy),
        .UART_uld_rx_data (UART_uld_rx_data),
        .triggerBlock_Mask(triggerBlock_Mask),
        .Sample_Div       (Sample_Div),
        .Rearm            (Rearm),
        .cmd_valid        (cmd_valid),
        .cmd_error        (cmd_error),
        .state_debug      (state_debug)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // UART RX buffer model: a byte is popped on the unload strobe and shown the next cycle.
    logic [7:0] rxq[$];

    task automatic push_byte(input logic [7:0] b);
        rxq.push_back(b);
        UART_rxempty = 1'b0;
    endtask

    always @(negedge clk) begin
        if (UART_uld_rx_data && rxq.size() > 0) UART_rxdata = rxq.pop_front();
        UART_rxempty = (rxq.size() == 0);
    end

    // Reference model at command level.
    typedef struct packed {
        logic [2:0]  mask;
        logic [15:0] div;
        logic        rearm;
    } exp_t;

    exp_t       expq[$];
    logic [2:0]  m_mask;
    logic [15:0] m_div;
    logic        m_err;

    function automatic int nargs_of(input logic [7:0] op);
        if (op == 8'h4D) return 1;
        if (op == 8'h44) return 2;
        if (op == 8'h52) return 0;
        return -1;
    endfunction

    task automatic model_cmd(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1);
        case (nargs_of(op))
            1: m_mask = a0[2:0];
            2: m_div = {a1, a0};
            default: ;
        endcase
        if (nargs_of(op) < 0) begin
            m_err = 1'b1;
        end else begin
            m_err = 1'b0;
            expq.push_back('{mask: m_mask, div: m_div, rearm: (op == 8'h52)});
        end
    endtask

    task automatic model_reset();
        m_mask = 3'b111;
        m_div  = 16'd0;
        m_err  = 1'b0;
        expq.delete();
    endtask

    // Scoreboard monitor.
    int   ncyc = 0;
    int   last_uld = -1;
    int   uld_count = 0;
    exp_t e;

    always @(negedge clk) begin
        ncyc++;
        if (UART_uld_rx_data) begin
            uld_count++;
            if (last_uld >= 0) check("uld_spacing", 32'(ncyc - last_uld >= 4), 1);
            last_uld = ncyc;
        end
        if (Rearm) check("rearm_without_cmd_valid", cmd_valid, 1);
        if (cmd_valid) begin
            if (expq.size() == 0) begin
                check("unexpected_cmd_valid", cmd_valid, 0);
            end else begin
                e = expq.pop_front();
                check("sb_mask", triggerBlock_Mask, e.mask);
                check("sb_div", Sample_Div, e.div);
                check("sb_rearm", Rearm, e.rearm);
                check("sb_error_cleared", cmd_error, 0);
            end
        end
    end

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (state_debug != s && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, state_debug, s);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(rxq.size() == 0 && state_debug == 3'd0 && UART_rxempty) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 300), 1);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1,
                            input int gap_max);
        int na = nargs_of(op);
        model_cmd(op, a0, a1);
        push_byte(op);
        for (int i = 0; i < na; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            push_byte(i == 0 ? a0 : a1);
        end
    endtask

    task automatic check_regs(input string name);
        check({name, "_mask"}, triggerBlock_Mask, m_mask);
        check({name, "_div"}, Sample_Div, m_div);
        check({name, "_err"}, cmd_error, m_err);
    endtask

    initial begin
        int uld0;
        int cnt;
        logic [7:0] op;
        logic [7:0] ops[3];
        bit busy;

        ops = '{8'h4D, 8'h44, 8'h52};
        rst = 1'b1;
        UART_rxempty = 1'b1;
        UART_rxdata = 8'h00;
        capture_busy = 1'b0;
        model_reset();

        // Reset.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mask", triggerBlock_Mask, 3'b111);
        check("rst_div", Sample_Div, 0);
        check("rst_rearm", Rearm, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_error", cmd_error, 0);
        check("rst_uld", UART_uld_rx_data, 0);
        check("rst_state", state_debug, 0);

        // 'M' 0xFA with exact completion latency after the last byte.
        uld0 = uld_count;
        model_cmd(8'h4D, 8'hFA, 8'h00);
        push_byte(8'h4D);
        wait_state(3'd4, "m_wait_arg");
        push_byte(8'hFA);
        repeat (4) @(negedge clk);
        check("m_latency_early_mask", triggerBlock_Mask, 3'b111);
        check("m_latency_early_valid", cmd_valid, 0);
        @(negedge clk);
        check("m_latency_mask", triggerBlock_Mask, 3'b010);
        check("m_latency_valid", cmd_valid, 1);
        @(negedge clk);
        check("m_valid_one_cycle", cmd_valid, 0);
        check("m_uld_strobes", 32'(uld_count - uld0), 2);

        // 'D' held off by capture_busy.
        capture_busy = 1'b1;
        send_cmd(8'h44, 8'h34, 8'h12, 0);
        wait_state(3'd5, "d_reach_apply");
        repeat (3) @(negedge clk);
        check("d_busy_div_held", Sample_Div, 0);
        check("d_busy_state", state_debug, 5);
        capture_busy = 1'b0;
        @(negedge clk);
        check("d_div_applied", Sample_Div, 16'h1234);
        check("d_cmd_valid", cmd_valid, 1);
        wait_idle("d_idle");

        // Argument timeout.
        push_byte(8'h4D);
        wait_state(3'd4, "to_wait_arg");
        cnt = 1;
        for (int i = 0; i < 100 && state_debug == 3'd4; i++) begin
            @(negedge clk);
            if (state_debug == 3'd4) cnt++;
        end
        m_err = 1'b1;
        check("to_wait_cycles", cnt, Timeout);
        check("to_state_idle", state_debug, 0);
        check_regs("to");
        send_cmd(8'h52, 8'h00, 8'h00, 0);
        wait_idle("r_idle");
        check_regs("r_after_to");

        // Byte arriving in the final timeout cycle wins over expiry.
        push_byte(8'h4D);
        model_cmd(8'h4D, 8'h05, 8'h00);
        wait_state(3'd4, "edge_wait_arg");
        repeat (Timeout - 1) @(negedge clk);
        check("edge_still_waiting", state_debug, 4);
        push_byte(8'h05);
        wait_idle("edge_idle");
        check_regs("edge");

        // Unknown opcode, then recovery.
        send_cmd(8'h7E, 8'h00, 8'h00, 0);
        wait_idle("unk_idle");
        check_regs("unk");
        send_cmd(8'h4D, 8'h01, 8'h00, 0);
        wait_idle("unk_recover_idle");
        check_regs("unk_recover");

        // Reset in the middle of a 'D' command.
        push_byte(8'h44);
        wait_state(3'd4, "rm_wait_arg0");
        push_byte(8'h34);
        repeat (6) @(negedge clk);
        check("rm_wait_arg1", state_debug, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rxq.delete();
        UART_rxempty = 1'b1;
        check("rm_cmd_valid", cmd_valid, 0);
        check("rm_state", state_debug, 0);
        check_regs("rm");
        send_cmd(8'h52, 8'h00, 8'h00, 0);
        wait_idle("rm_rearm_idle");
        check_regs("rm_after");

        // Randomized command stream.
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 8'($urandom_range(0, 255));
                while (nargs_of(op) >= 0);
            end else begin
                op = ops[$urandom_range(0, 2)];
            end
            busy = (nargs_of(op) >= 0) && ($urandom_range(0, 2) == 0);
            capture_busy = busy;
            send_cmd(op, 8'($urandom), 8'($urandom), 6);
            if (busy) begin
                wait_state(3'd5, "rnd_apply");
                repeat ($urandom_range(0, 5)) @(negedge clk);
                capture_busy = 1'b0;
            end
            wait_idle("rnd_idle");
            check_regs("rnd");
        end
        check("final_sb_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got hang, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_command_decoder.md
# uart_command_decoder

Receive-side command decoder for the logic analyzer's UART link. It unloads bytes from the UART receiver, assembles framed host commands (opcode plus 0–2 argument bytes), and updates the capture configuration registers: trigger mask, sample-rate divider and re-arm. Updates are applied only while the capture/readout controller is idle, so an in-flight capture or transfer never sees its configuration change. The block sits between the UART RX port and the trigger block and sampler. It is the host-to-device counterpart of the FIFO-to-UART readout path.

## Interface
- TIMEOUT_CYCLES, 500000, maximum idle cycles between bytes of one command (10 ms at 50 MHz)
- MASK_RESET, 3'b111, reset value of triggerBlock_Mask
- DIV_RESET, 16'd0, reset value of Sample_Div
---
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- UART_rxempty  in  1  high when the UART RX buffer holds no byte
- UART_rxdata  in  8  UART RX byte, valid the cycle after UART_uld_rx_data
- capture_busy  in  1  high while the capture/readout controller is not in IDLE
- UART_uld_rx_data  out  1  one-cycle unload strobe to the UART
- triggerBlock_Mask  out  3  trigger input mask
- Sample_Div  out  16  sample clock divider
- Rearm  out  1  one-cycle pulse that resets and re-arms the trigger block
- cmd_valid  out  1  one-cycle pulse when a command has been applied
- cmd_error  out  1  sticky error flag
- state_debug  out  3  current FSM state

## Operation
- Opcodes:
  - 0x4D 'M', 1 argument: triggerBlock_Mask <= arg0[2:0]; arg0[7:3] ignored.
  - 0x44 'D', 2 arguments, little-endian: Sample_Div <= {arg1, arg0}.
  - 0x52 'R', 0 arguments: Rearm pulse.
- States, with encodings:
  - IDLE 0: byte index cleared. If !UART_rxempty, go to UNLOAD.
  - UNLOAD 1: UART_uld_rx_data=1. Go to LATCH.
  - LATCH 2: If the byte index is 0, store UART_rxdata as the opcode; otherwise store it as arg[idx-1]. Increment idx. Go to DECODE.
  - DECODE 3:
    - Unknown opcode: set cmd_error, go to IDLE.
    - All arguments received: go to APPLY.
    - Otherwise: clear the timeout counter, go to WAIT_ARG.
  - WAIT_ARG 4: Timeout counter increments every cycle.
    - If !UART_rxempty, go to UNLOAD.
    - Else if counter == TIMEOUT_CYCLES-1: set cmd_error, discard the partial command, go to IDLE.
  - APPLY 5: Hold while capture_busy=1. When capture_busy=0, write the target register, fire Rearm for 'R', fire cmd_valid, clear cmd_error, go to IDLE.
  - Other encodings: go to IDLE.
- Bytes that arrive during APPLY stay in the UART buffer. UART overrun is the UART's responsibility.
- Timeout counter width is $clog2(TIMEOUT_CYCLES). It saturates and never wraps.
- UART_uld_rx_data is a decode of state == UNLOAD. All other outputs are registered.

## Timing
- Reset values:
  - triggerBlock_Mask=MASK_RESET, Sample_Div=DIV_RESET.
  - Rearm=0, cmd_valid=0, cmd_error=0, UART_uld_rx_data=0.
  - state=IDLE, idx=0, counter=0.
- Per byte: UART_rxempty is seen low in cycle n. UNLOAD is cycle n+1, LATCH n+2, DECODE n+3.
- Command completion with capture_busy=0: APPLY is cycle n+4. Register update, Rearm and cmd_valid are visible in cycle n+5, each pulse exactly 1 cycle.
- Each extra argument byte adds ≥4 cycles.
- A byte and timeout expiry in the same WAIT_ARG cycle: the byte wins and no error is raised.
- capture_busy rising while in APPLY: the FSM keeps waiting and applies nothing until capture_busy falls.
- rst mid-command, in any state: the partial command is discarded and all outputs return to reset values in the next cycle. No strobe is issued from the aborted command.
- Minimum spacing between UART_uld_rx_data strobes is 4 cycles.

## Test plan
- Reset: assert rst 2 cycles -> Mask=3'b111, Sample_Div=0, all pulses 0, state_debug=0.
- Send 0x4D, 0xFA with capture_busy=0 -> Mask=3'b010 in cycle n+5 after the last byte, cmd_valid high 1 cycle, exactly two uld strobes.
- Send 0x44, 0x34, 0x12 while capture_busy=1 -> Sample_Div stays 0 and state_debug=5. Drop capture_busy -> Sample_Div=0x1234 the cycle after, with cmd_valid.
- Send 0x4D, then nothing, with TIMEOUT_CYCLES=16 -> cmd_error=1 after 16 WAIT_ARG cycles and Mask unchanged. Then send 0x52 -> Rearm pulse and cmd_error cleared.
- Send 0x7E -> cmd_error=1, no cmd_valid, FSM back in IDLE. Then 0x4D, 0x01 -> Mask=3'b001.
- Send 0x44, 0x34, then assert rst before arg1 -> Sample_Div=0 and no cmd_valid. A subsequent 0x52 is decoded normally.
